// File: rtl/pass_pipe.sv
// Multi-channel valid/ready register pipeline with a switchable combinational
// bypass; mode changes wait for the pipeline to drain so no word is lost.
module pass_pipe #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bypass,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CHANNELS*WIDTH-1:0]        in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHANNELS*WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy,
    output logic                             bypass_active
);

    localparam int DATA_W = CHANNELS * WIDTH;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  stage_valid;
    logic [DATA_W-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0]  stage_ready;
    logic [DEPTH-1:0]  src_valid;
    logic [DATA_W-1:0] src_data [DEPTH];
    logic              ready_acc;
    logic              switch_pending;
    logic              accept;

    assign switch_pending = (bypass != bypass_active);
    assign accept         = in_valid && in_ready && !bypass_active;

    // A stage may load when it is empty or anything downstream of it can move;
    // written as a running OR so the ready chain has no self-referencing vector.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or
        // loop; a path that skips an assignment would otherwise infer a latch.
        ready_acc   = out_ready;
        stage_ready = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready_acc      = ready_acc || !stage_valid[i];
            stage_ready[i] = ready_acc;
        end
    end

    always_comb begin
        src_valid    = '0;
        src_valid[0] = accept;
        src_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = stage_valid[i-1];
            src_data[i]  = stage_data[i-1];
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(stage_valid[i]);
        end
    end

    // While a switch is pending nothing new enters; stored words still drain.
    always_comb begin
        if (bypass_active) begin
            out_valid = in_valid && !switch_pending;
            out_data  = in_data;
            in_ready  = out_ready && !switch_pending;
        end else begin
            out_valid = stage_valid[DEPTH-1];
            out_data  = stage_data[DEPTH-1];
            in_ready  = stage_ready[0] && !switch_pending;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid   <= '0;
            bypass_active <= 1'b0;
            // NOTE: the data registers are cleared as well, not just the valid
            // bits, so out_data reads zero while reset is held.
            for (int i = 0; i < DEPTH; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignments so every stage
            // samples its upstream neighbour's pre-edge value.
            for (int i = 0; i < DEPTH; i++) begin
                if (stage_ready[i]) begin
                    stage_valid[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        stage_data[i] <= src_data[i];
                    end
                end
            end
            if (switch_pending && occupancy == '0) begin
                bypass_active <= bypass;
            end
        end
    end

endmodule

// File: tb/tb_pass_pipe.sv
// Bench for pass_pipe: a DEPTH=3 instance under directed tests and a DEPTH=1
// instance under random handshakes, each checked every cycle by a queue model.
module tb_pass_pipe;

    localparam int DEPTH_A = 3;
    localparam int DEPTH_B = 1;

    logic        clk = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        a_rst, a_bypass, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_bypass_active;
    logic [15:0] a_in_data, a_out_data;
    logic [1:0]  a_occupancy;

    logic        b_rst, b_bypass, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_bypass_active;
    logic [15:0] b_in_data, b_out_data;
    logic [0:0]  b_occupancy;

    logic [15:0] a_seen[$];
    logic [15:0] b_sent[$];
    logic [15:0] b_got[$];

    always #5 clk = ~clk;

    pass_pipe #(.WIDTH(8), .CHANNELS(2), .DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst(a_rst), .bypass(a_bypass),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occupancy), .bypass_active(a_bypass_active)
    );

    pass_pipe #(.WIDTH(8), .CHANNELS(2), .DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rst(b_rst), .bypass(b_bypass),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy), .bypass_active(b_bypass_active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model A: words in flight kept as a FIFO with their accept-edge stamps;
    // the oldest word is visible once it has been inside for DEPTH edges.
    initial begin : model_a
        logic [15:0] qd[$];
        int          qt[$];
        logic        mba, pend, exp_ov, exp_ir, acc, emit, sw, cap_byp;
        logic [15:0] cap_data;
        int          ncyc;
        mba  = 1'b0;
        ncyc = 0;
        forever begin
            @(negedge clk);
            if (a_rst) begin
                qd.delete();
                qt.delete();
                mba = 1'b0;
                check("a_rst_out_valid", a_out_valid, 0);
                check("a_rst_occupancy", a_occupancy, 0);
                check("a_rst_out_data", a_out_data, 0);
                check("a_rst_bypass_active", a_bypass_active, 0);
            end else begin
                pend = (a_bypass != mba);
                if (mba) begin
                    exp_ov = a_in_valid && !pend;
                    exp_ir = a_out_ready && !pend;
                    check("a_byp_out_valid", a_out_valid, exp_ov);
                    check("a_byp_in_ready", a_in_ready, exp_ir);
                    check("a_byp_occupancy", a_occupancy, 0);
                    if (exp_ov) check("a_byp_out_data", a_out_data, a_in_data);
                    acc = 1'b0;
                    emit = 1'b0;
                    sw = pend;
                end else begin
                    exp_ov = (qd.size() > 0) && (ncyc - qt[0] + 1 >= DEPTH_A);
                    exp_ir = !pend && (qd.size() < DEPTH_A || a_out_ready);
                    check("a_out_valid", a_out_valid, exp_ov);
                    check("a_in_ready", a_in_ready, exp_ir);
                    check("a_occupancy", a_occupancy, qd.size());
                    if (exp_ov) check("a_out_data", a_out_data, qd[0]);
                    acc  = a_in_valid && exp_ir;
                    emit = exp_ov && a_out_ready;
                    sw   = pend && (qd.size() == 0);
                end
                check("a_bypass_active", a_bypass_active, mba);
                cap_data = a_in_data;
                cap_byp  = a_bypass;
                @(posedge clk);
                if (!a_rst) begin
                    ncyc++;
                    if (emit) begin
                        void'(qd.pop_front());
                        void'(qt.pop_front());
                    end
                    if (acc) begin
                        qd.push_back(cap_data);
                        qt.push_back(ncyc);
                    end
                    if (sw) mba = cap_byp;
                end
            end
        end
    end

    // Model B: same view for the single-stage slice (bypass held low).
    initial begin : model_b
        logic [15:0] qd[$];
        int          qt[$];
        logic        exp_ov, exp_ir, acc, emit;
        logic [15:0] cap_data;
        int          ncyc;
        ncyc = 0;
        forever begin
            @(negedge clk);
            if (b_rst) begin
                qd.delete();
                qt.delete();
                check("b_rst_out_valid", b_out_valid, 0);
                check("b_rst_occupancy", b_occupancy, 0);
            end else begin
                exp_ov = (qd.size() > 0) && (ncyc - qt[0] + 1 >= DEPTH_B);
                exp_ir = (qd.size() < DEPTH_B) || b_out_ready;
                check("b_out_valid", b_out_valid, exp_ov);
                check("b_in_ready", b_in_ready, exp_ir);
                check("b_occupancy", b_occupancy, qd.size());
                if (exp_ov) check("b_out_data", b_out_data, qd[0]);
                acc      = b_in_valid && exp_ir;
                emit     = exp_ov && b_out_ready;
                cap_data = b_in_data;
                @(posedge clk);
                if (!b_rst) begin
                    ncyc++;
                    if (emit) begin
                        void'(qd.pop_front());
                        void'(qt.pop_front());
                    end
                    if (acc) begin
                        qd.push_back(cap_data);
                        qt.push_back(ncyc);
                    end
                end
            end
        end
    end

    initial begin : recorder
        forever begin
            @(negedge clk);
            if (!a_rst && a_out_valid && a_out_ready && !a_bypass_active) a_seen.push_back(a_out_data);
            if (!b_rst && b_in_valid && b_in_ready) b_sent.push_back(b_in_data);
            if (!b_rst && b_out_valid && b_out_ready) b_got.push_back(b_out_data);
        end
    end

    task automatic test_a();
        int          nxt, n;
        logic        acc, stall_prev, saw_full;
        logic [15:0] held;
        logic [7:0]  v;

        // Single word latency through three stages.
        a_in_valid = 1'b1;
        a_in_data  = 16'h1234;
        a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("t1_occ_e0", a_occupancy, 1);
        check("t1_ov_e0", a_out_valid, 0);
        tick();
        @(negedge clk);
        check("t1_ov_e1", a_out_valid, 0);
        tick();
        @(negedge clk);
        check("t1_ov_e2", a_out_valid, 1);
        check("t1_data_e2", a_out_data, 16'h1234);
        check("t1_occ_e2", a_occupancy, 1);
        tick();
        @(negedge clk);
        check("t1_ov_e3", a_out_valid, 0);

        // Ten-word stream with a four-cycle downstream stall.
        tick();
        a_seen.delete();
        nxt = 0;
        stall_prev = 1'b0;
        saw_full = 1'b0;
        held = '0;
        for (int c = 0; c < 40 && a_seen.size() < 10; c++) begin
            a_in_valid  = (nxt < 10);
            v           = 8'(nxt);
            a_in_data   = {v, v ^ 8'hF0};
            a_out_ready = !(c >= 4 && c <= 7);
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            if (a_occupancy == 2'd3 && !a_out_ready && !a_in_ready) saw_full = 1'b1;
            if (stall_prev) check("t2_stall_hold", a_out_data, held);
            stall_prev = a_out_valid && !a_out_ready;
            held = a_out_data;
            tick();
            if (acc) nxt++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        check("t2_saw_full_stall", saw_full, 1);
        check("t2_count", a_seen.size(), 10);
        for (int i = 0; i < a_seen.size(); i++) begin
            v = 8'(i);
            check("t2_order", a_seen[i], {v, v ^ 8'hF0});
        end

        // Switch to bypass with two words held.
        a_seen.delete();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'hAA01;
        tick();
        a_in_data   = 16'hAA02;
        tick();
        a_in_data   = 16'h5555;
        a_bypass    = 1'b1;
        @(negedge clk);
        check("t3_occ_held", a_occupancy, 2);
        check("t3_in_ready_pend", a_in_ready, 0);
        tick();
        a_out_ready = 1'b1;
        n = 0;
        while (a_occupancy != 0 && n < 20) begin
            tick();
            n++;
        end
        check("t3_drain_bound", n < 20, 1);
        @(negedge clk);
        check("t3_ba_before", a_bypass_active, 0);
        tick();
        check("t3_ba_after", a_bypass_active, 1);
        check("t3_byp_ov", a_out_valid, 1);
        check("t3_byp_data0", a_out_data, 16'h5555);
        a_in_data = 16'h7777;
        #1;
        check("t3_byp_data1", a_out_data, 16'h7777);
        check("t3_byp_in_ready", a_in_ready, 1);
        a_in_valid = 1'b0;
        check("t3_drained_n", a_seen.size(), 2);
        if (a_seen.size() == 2) begin
            check("t3_drained_0", a_seen[0], 16'hAA01);
            check("t3_drained_1", a_seen[1], 16'hAA02);
        end

        // Back to pipelined mode: one blocked cycle, then DEPTH latency.
        tick();
        a_in_valid = 1'b1;
        a_in_data  = 16'h3C3C;
        a_bypass   = 1'b0;
        @(negedge clk);
        check("t4_pend_in_ready", a_in_ready, 0);
        check("t4_pend_ov", a_out_valid, 0);
        tick();
        @(negedge clk);
        check("t4_ba_cleared", a_bypass_active, 0);
        check("t4_in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("t4_ov_e0", a_out_valid, 0);
        tick();
        @(negedge clk);
        check("t4_ov_e1", a_out_valid, 0);
        tick();
        @(negedge clk);
        check("t4_ov_e2", a_out_valid, 1);
        check("t4_data_e2", a_out_data, 16'h3C3C);
        tick();

        // Fill all stages, then reset asynchronously mid-cycle.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_in_data = 16'hD100 + 16'(k);
            tick();
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        check("t5_occ_full", a_occupancy, 3);
        check("t5_in_ready_full", a_in_ready, 0);
        @(posedge clk);
        #3;
        a_rst = 1'b1;
        #1;
        check("t5_rst_ov", a_out_valid, 0);
        check("t5_rst_occ", a_occupancy, 0);
        check("t5_rst_data", a_out_data, 0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        a_seen.delete();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 16'h0F0F;
        @(negedge clk);
        check("t5_first_accept", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        repeat (5) tick();
        check("t5_post_count", a_seen.size(), 1);
        if (a_seen.size() == 1) check("t5_post_word", a_seen[0], 16'h0F0F);
    endtask

    task automatic test_b();
        int sent_n;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 16'hBEEF;
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_lat_ov", b_out_valid, 1);
        check("b_lat_data", b_out_data, 16'hBEEF);
        check("b_lat_occ", b_occupancy, 1);
        tick();
        b_sent.delete();
        b_got.delete();
        for (int c = 0; c < 150; c++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = 16'($urandom);
            b_out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (3) tick();
        sent_n = b_sent.size();
        check("b_seq_len", b_got.size(), sent_n);
        for (int i = 0; i < sent_n && i < b_got.size(); i++) begin
            check("b_seq_word", b_got[i], b_sent[i]);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run still active at %0t, required summary earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin : main
        a_rst = 1'b1;  a_bypass = 1'b0;  a_in_valid = 1'b0;  a_out_ready = 1'b0;  a_in_data = '0;
        b_rst = 1'b1;  b_bypass = 1'b0;  b_in_valid = 1'b0;  b_out_ready = 1'b0;  b_in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("init_ov", a_out_valid, 0);
        check("init_occ", a_occupancy, 0);
        check("init_data", a_out_data, 0);
        check("init_ba", a_bypass_active, 0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        fork
            test_a();
            test_b();
        join
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pass_pipe.md
PASS_PIPE -- requirements
Module: pass_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: bits per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 2: independent lanes carried in parallel.
REQ-003 The block SHALL have parameter DEPTH, default 2: register stages; legal range 1..16.
REQ-004 Port clk SHALL be: input, 1 bit, single clock; all state changes on its rising edge.
REQ-005 Port rst SHALL be: input, 1 bit, asynchronous, active-high reset.
REQ-006 Port bypass SHALL be: input, 1 bit, mode request (1 = combinational pass-through, 0 = pipelined).
REQ-007 Port in_valid SHALL be: input, 1 bit, upstream word present.
REQ-008 Port in_ready SHALL be: output, 1 bit, block accepts a word this cycle.
REQ-009 Port in_data SHALL be: input, CHANNELS*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port out_valid SHALL be: output, 1 bit, downstream word present.
REQ-011 Port out_ready SHALL be: input, 1 bit, downstream accepts.
REQ-012 Port out_data SHALL be: output, CHANNELS*WIDTH bits, with the same channel packing as in_data.
REQ-013 Port occupancy SHALL be: output, clog2(DEPTH+1) bits, count of valid stages.
REQ-014 Port bypass_active SHALL be: output, 1 bit, registered current mode.

Function
REQ-015 A transfer SHALL occur on a port only at a rising edge where valid and ready are both high.
REQ-016 Pipelined mode SHALL hold DEPTH stages, each a valid bit plus one full CHANNELS*WIDTH word; stage 0 is fed from in_*, stage DEPTH-1 drives out_*.
REQ-017 Stage advance SHALL follow ready_i = !valid_i || ready_(i+1), with ready_DEPTH = out_ready and in_ready = ready_0 (bubbles collapse; a combinational out_ready->in_ready path is permitted).
REQ-018 Latency SHALL be exactly DEPTH cycles into an empty pipeline: a word accepted at edge t gives out_valid=1 with that word in the cycle after edge t+DEPTH-1.
REQ-019 With in_valid and out_ready held high, throughput SHALL be one word per cycle with no bubbles.
REQ-020 Word order SHALL be preserved, and channels SHALL never be reordered or mixed.
REQ-021 While out_valid && !out_ready, out_data SHALL hold stable.
REQ-022 When all stages are valid and out_ready=0, in_ready SHALL be 0 and occupancy SHALL be DEPTH.
REQ-023 occupancy SHALL equal the number of set stage valid bits (0..DEPTH), updated each edge; simultaneous accept and emit SHALL leave it unchanged.
REQ-024 In bypass mode (bypass_active=1, no switch pending), out_valid=in_valid, out_data=in_data and in_ready=out_ready SHALL hold combinationally with zero latency, and stage valid bits SHALL stay 0.
REQ-025 A switch SHALL be pending whenever bypass != bypass_active; while pending, in_ready SHALL be 0, and if bypass_active=1, out_valid SHALL be 0.
REQ-026 In pipelined mode, a pending switch SHALL let stored words continue to drain normally.
REQ-027 bypass_active SHALL load bypass at the first edge where a switch is pending and occupancy=0.
REQ-028 No word SHALL be lost or duplicated across a mode switch.
REQ-029 For DEPTH=1 the block SHALL behave as a single-stage register slice, with the same rules.

Reset
REQ-030 While rst=1, all stage valid bits SHALL clear asynchronously, and out_valid=0, occupancy=0, stage data=0, out_data=0 and bypass_active=0.
REQ-031 Assertion of rst mid-transfer SHALL discard all held words; none SHALL be emitted after release.
REQ-032 After rst release, the first acceptance SHALL be possible at the first rising edge; if bypass=1 at release, a single pending-switch cycle SHALL precede bypass operation.

Verification
REQ-033 The bench SHALL cover: WIDTH=8, CHANNELS=2, DEPTH=3, out_ready=1, in_data=0x12_34 accepted at edge 0 -> out_valid=1 with out_data=0x1234 in the cycle after edge 2; occupancy 1 before the word is emitted.
REQ-034 The bench SHALL cover: stream of 10 words 0..9, out_ready=0 for cycles 4-7 -> in_ready drops once occupancy=3, outputs 0..9 in order, none lost or repeated, out_data stable while stalled.
REQ-035 The bench SHALL cover: pipelined with 2 words held, bypass driven 1 -> in_ready=0, both words drain, bypass_active rises at the edge where occupancy=0, after which out_data follows in_data in the same cycle.
REQ-036 The bench SHALL cover: bypass mode, bypass driven 0 -> one cycle with in_ready=0 and out_valid=0, then pipelined operation with latency DEPTH.
REQ-037 The bench SHALL cover: rst pulsed asynchronously mid-cycle with occupancy=3 -> out_valid=0 and occupancy=0 immediately, no pre-reset word appears afterwards.
REQ-038 The bench SHALL cover: DEPTH=1 with random in_valid/out_ready -> output sequence equals the accepted input sequence, one-cycle latency when unstalled.
